// File: rtl/eth_hdr_axis_tx.sv
// Ethernet frame serializer: parallel header + byte payload -> one byte stream.
// Sends the 14-byte header, passes the payload through, and optionally zero-pads
// short frames up to MIN_FRAME_LENGTH. The output sits behind a 2-entry skid buffer,
// so every m_axis output comes straight from a register.
module eth_hdr_axis_tx #(
  parameter int ENABLE_PADDING   = 1,
  parameter int MIN_FRAME_LENGTH = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_eth_hdr_valid,
  output logic        s_eth_hdr_ready,
  input  logic [47:0] s_eth_dest_mac,
  input  logic [47:0] s_eth_src_mac,
  input  logic [15:0] s_eth_type,
  input  logic [7:0]  s_eth_payload_axis_tdata,
  input  logic        s_eth_payload_axis_tvalid,
  output logic        s_eth_payload_axis_tready,
  input  logic        s_eth_payload_axis_tlast,
  input  logic        s_eth_payload_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WRITE_HEADER, WRITE_PAYLOAD, WRITE_PAD} state_t;

  localparam logic [16:0] MIN_LEN = 17'(MIN_FRAME_LENGTH);

  state_t      state, state_next;
  logic [15:0] count, count_next;
  logic [16:0] count_inc;
  logic [15:0] count_sat;
  logic [47:0] dest_mac, src_mac;
  logic [15:0] eth_type;
  logic [111:0] hdr_shift;
  logic        frame_user, frame_user_next;
  logic        latch_hdr;
  logic        hdr_fire, payload_fire;

  // Internal byte interface between the FSM and the skid buffer.
  logic [7:0]  tdata_int;
  logic        tvalid_int, tlast_int, tuser_int;
  logic        ready_int, ready_int_early;

  // Skid buffer temp entry and steering.
  logic [7:0]  temp_tdata;
  logic        temp_tvalid, temp_tlast, temp_tuser;
  logic        out_valid_next, temp_valid_next;
  logic        int_to_out, int_to_temp, temp_to_out;

  assign hdr_fire     = s_eth_hdr_ready & s_eth_hdr_valid;
  assign payload_fire = s_eth_payload_axis_tready & s_eth_payload_axis_tvalid;
  assign count_inc    = {1'b0, count} + 17'd1;
  assign count_sat    = count_inc[16] ? 16'hFFFF : count_inc[15:0];
  // Header byte N lands in the top byte after shifting by N bytes.
  assign hdr_shift    = {dest_mac, src_mac, eth_type} << {count[3:0], 3'b000};

  // Ready for the internal interface next cycle: free slot somewhere in the buffer.
  assign ready_int_early = m_axis_tready | (~temp_tvalid & (~m_axis_tvalid | ~tvalid_int));

  // Frame sequencing: decides the next state and the byte offered to the skid buffer.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned and infers a latch.
    state_next      = state;
    count_next      = count;
    frame_user_next = frame_user;
    latch_hdr       = 1'b0;
    tdata_int       = 8'h00;
    tvalid_int      = 1'b0;
    tlast_int       = 1'b0;
    tuser_int       = 1'b0;
    unique case (state)
      IDLE: begin
        count_next = '0;
        if (hdr_fire) begin
          latch_hdr  = 1'b1;
          state_next = WRITE_HEADER;
          if (ready_int) begin
            tdata_int  = s_eth_dest_mac[47:40];
            tvalid_int = 1'b1;
            count_next = 16'd1;
          end
        end
      end
      WRITE_HEADER: begin
        if (ready_int) begin
          tdata_int  = hdr_shift[111:104];
          tvalid_int = 1'b1;
          count_next = count_sat;
          if (count == 16'd13) state_next = WRITE_PAYLOAD;
        end
      end
      WRITE_PAYLOAD: begin
        if (payload_fire) begin
          tdata_int  = s_eth_payload_axis_tdata;
          tvalid_int = 1'b1;
          count_next = count_sat;
          if (s_eth_payload_axis_tlast) begin
            if (ENABLE_PADDING != 0 && count_inc < MIN_LEN) begin
              frame_user_next = s_eth_payload_axis_tuser;
              state_next      = WRITE_PAD;
            end else begin
              tlast_int  = 1'b1;
              tuser_int  = s_eth_payload_axis_tuser;
              state_next = IDLE;
            end
          end
        end
      end
      WRITE_PAD: begin
        if (ready_int) begin
          tvalid_int = 1'b1;
          count_next = count_sat;
          if (count_inc >= MIN_LEN) begin
            tlast_int  = 1'b1;
            tuser_int  = frame_user;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Skid buffer steering: straight to the output when it can move, else park in temp.
  always_comb begin
    out_valid_next  = m_axis_tvalid;
    temp_valid_next = temp_tvalid;
    int_to_out      = 1'b0;
    int_to_temp     = 1'b0;
    temp_to_out     = 1'b0;
    if (ready_int) begin
      if (m_axis_tready || !m_axis_tvalid) begin
        out_valid_next = tvalid_int;
        int_to_out     = 1'b1;
      end else begin
        temp_valid_next = tvalid_int;
        int_to_temp     = 1'b1;
      end
    end else if (m_axis_tready) begin
      out_valid_next  = temp_tvalid;
      temp_valid_next = 1'b0;
      temp_to_out     = 1'b1;
    end
  end

  // All state, latched header and skid buffer registers.
  // NOTE: datapath registers are reset too, so every output reads 0 during reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                     <= IDLE;
      count                     <= '0;
      frame_user                <= 1'b0;
      dest_mac                  <= '0;
      src_mac                   <= '0;
      eth_type                  <= '0;
      s_eth_hdr_ready           <= 1'b0;
      s_eth_payload_axis_tready <= 1'b0;
      busy                      <= 1'b0;
      ready_int                 <= 1'b0;
      m_axis_tdata              <= '0;
      m_axis_tvalid             <= 1'b0;
      m_axis_tlast              <= 1'b0;
      m_axis_tuser              <= 1'b0;
      temp_tdata                <= '0;
      temp_tvalid               <= 1'b0;
      temp_tlast                <= 1'b0;
      temp_tuser                <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state                     <= state_next;
      count                     <= count_next;
      frame_user                <= frame_user_next;
      s_eth_hdr_ready           <= (state_next == IDLE);
      s_eth_payload_axis_tready <= ready_int_early & (state_next == WRITE_PAYLOAD);
      busy                      <= (state_next != IDLE);
      ready_int                 <= ready_int_early;
      m_axis_tvalid             <= out_valid_next;
      temp_tvalid               <= temp_valid_next;
      if (latch_hdr) begin
        dest_mac <= s_eth_dest_mac;
        src_mac  <= s_eth_src_mac;
        eth_type <= s_eth_type;
      end
      if (int_to_out) begin
        m_axis_tdata <= tdata_int;
        m_axis_tlast <= tlast_int;
        m_axis_tuser <= tuser_int;
      end else if (temp_to_out) begin
        m_axis_tdata <= temp_tdata;
        m_axis_tlast <= temp_tlast;
        m_axis_tuser <= temp_tuser;
      end
      if (int_to_temp) begin
        temp_tdata <= tdata_int;
        temp_tlast <= tlast_int;
        temp_tuser <= tuser_int;
      end
    end
  end

endmodule
